clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider_if.sv | 9 +
 rtl/clock_divider.sv | 44 ++++
 tb/tb_clock_divider.sv | 131 +++++++++++++
 3 files changed

// File: rtl/clock_divider_if.sv
// Divided-clock output bundle: fabric-rate clk_out plus its rising-edge strobe.
// Both signals are registered at the source and have no flow control.
interface clock_divider_if;
  logic clk_out;
  logic tick;

  modport master (output clk_out, output tick);
  modport slave  (input clk_out, input tick);
endinterface

// File: rtl/clock_divider.sv
// Divides clk_74 by DIVIDER into a registered clk_out (low phase gets the odd cycle) plus a one-cycle tick.
// Outputs are one flop deep behind the counter state; free-running with no backpressure.
module clock_divider #(
  parameter int DIVIDER = 7400000
) (
  input  logic             clk_74,
  input  logic             reset_n,
  clock_divider_if.master  div_if
);

  localparam int CW = (DIVIDER <= 2) ? 1 : $clog2(DIVIDER);
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] LOW  = CW'(DIVIDER - DIVIDER / 2);

  if (DIVIDER < 2) begin : g_bad_divider
    $fatal(1, "clock_divider: DIVIDER must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clk_out_q;
  logic          tick_q;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // Outputs are decoded from the next count so they line up with cnt in the same cycle.
  always_ff @(posedge clk_74) begin
    if (reset_n) begin
      cnt       <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk_out_q <= (cnt_nxt >= LOW);
      tick_q    <= (cnt_nxt == LOW);
    end
  end

  assign div_if.clk_out = clk_out_q;
  assign div_if.tick    = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider across several DIVIDER values, including a mid-period reset.
module tb_clock_divider;

  logic clk_74 = 1'b0;
  logic reset_n;
  logic rst6;

  always #5 clk_74 = ~clk_74;

  clock_divider_if if2 ();
  clock_divider_if if4 ();
  clock_divider_if if5 ();
  clock_divider_if if6 ();
  clock_divider_if ifk ();
  clock_divider_if ifb ();

  clock_divider #(.DIVIDER(2))          dut2    (.clk_74(clk_74), .reset_n(reset_n), .div_if(if2));
  clock_divider #(.DIVIDER(4))          dut4    (.clk_74(clk_74), .reset_n(reset_n), .div_if(if4));
  clock_divider #(.DIVIDER(5))          dut5    (.clk_74(clk_74), .reset_n(reset_n), .div_if(if5));
  clock_divider #(.DIVIDER(6))          dut6    (.clk_74(clk_74), .reset_n(rst6),    .div_if(if6));
  clock_divider #(.DIVIDER(1000))       dutk    (.clk_74(clk_74), .reset_n(reset_n), .div_if(ifk));
  clock_divider #(.DIVIDER(2147483647)) dut_big (.clk_74(clk_74), .reset_n(reset_n), .div_if(ifb));

  int n_checks = 0;
  int n_errors = 0;
  int ticks_k  = 0;

  // Expected waveforms, bit i = cycle i after reset release.
  logic [31:0] d2_clk_pat  = 32'h0000_0002;
  logic [31:0] d4_clk_pat  = 32'h0000_00CC;
  logic [31:0] d4_tick_pat = 32'h0000_0044;
  logic [31:0] d5_clk_pat  = 32'h0000_0018;
  logic [31:0] d5_tick_pat = 32'h0000_0008;
  logic [31:0] d6_clk_pat  = 32'h0001_C718;
  logic [31:0] d6_tick_pat = 32'h0000_4108;

  function automatic logic exp_bit(input logic [31:0] pat, input int idx);
    return pat[idx[4:0]];
  endfunction

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int k);
    chk1({tag, "_d2_clk"},    k, if2.clk_out, 1'b0);
    chk1({tag, "_d2_tick"},   k, if2.tick,    1'b0);
    chk1({tag, "_d4_clk"},    k, if4.clk_out, 1'b0);
    chk1({tag, "_d4_tick"},   k, if4.tick,    1'b0);
    chk1({tag, "_d5_clk"},    k, if5.clk_out, 1'b0);
    chk1({tag, "_d5_tick"},   k, if5.tick,    1'b0);
    chk1({tag, "_d1000_clk"}, k, ifk.clk_out, 1'b0);
    chk32({tag, "_d5_cnt"},   k, 32'(dut5.cnt), 32'd0);
  endtask

  task automatic chk_small(input string tag, input int k);
    chk1({tag, "_d2_clk"},  k, if2.clk_out, exp_bit(d2_clk_pat, k % 2));
    chk1({tag, "_d2_tick"}, k, if2.tick,    exp_bit(d2_clk_pat, k % 2));
    chk1({tag, "_d4_clk"},  k, if4.clk_out, exp_bit(d4_clk_pat, k % 8));
    chk1({tag, "_d4_tick"}, k, if4.tick,    exp_bit(d4_tick_pat, k % 8));
    chk1({tag, "_d5_clk"},  k, if5.clk_out, exp_bit(d5_clk_pat, k % 5));
    chk1({tag, "_d5_tick"}, k, if5.tick,    exp_bit(d5_tick_pat, k % 5));
    chk32({tag, "_d5_cnt"}, k, 32'(dut5.cnt), k % 5);
  endtask

  initial begin
    reset_n = 1'b1;
    rst6    = 1'b1;

    // Held reset: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_74);
      chk_zero("rst_hold", i);
      chk1("rst_hold_d6_clk", i, if6.clk_out, 1'b0);
    end

    // Release; this negedge is cycle 0 (cnt=0, clk_out=0).
    reset_n = 1'b0;
    rst6    = 1'b0;
    for (int k = 0; k < 2600; k++) begin
      if (k > 0) @(negedge clk_74);
      if (k < 20) chk_small("run", k);
      if (k < 18) begin
        chk1("d6_clk",  k, if6.clk_out, exp_bit(d6_clk_pat, k));
        chk1("d6_tick", k, if6.tick,    exp_bit(d6_tick_pat, k));
      end
      chk1("d1000_clk",  k, ifk.clk_out, (k % 1000) >= 500);
      chk1("d1000_tick", k, ifk.tick,    (k % 1000) == 500);
      if (ifk.tick) ticks_k++;
      if (k < 20 || (k % 500) == 0 || k == 2599) begin
        chk32("big_cnt", k, 32'(dut_big.cnt), k);
        chk1("big_clk",  k, ifb.clk_out, 1'b0);
      end
      // One-cycle reset pulse for DIVIDER=6 during its high phase.
      if (k == 4) rst6 = 1'b1;
      if (k == 5) rst6 = 1'b0;
    end
    chk32("d1000_tick_count", 2600, ticks_k, 32'd3);

    // Reset while DIVIDER=5 sits at terminal count and DIVIDER=1000 is high.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_74);
      chk_zero("mid_rst", i);
    end

    reset_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk_74);
      chk_small("restart", k);
      chk1("restart_d1000_clk", k, ifk.clk_out, 1'b0);
      chk32("restart_big_cnt", k, 32'(dut_big.cnt), k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
